// File: rtl/cpu_irq_ctrl.sv
// cpu_irq_ctrl: machine-mode interrupt controller with mtime timer, local sources, fixed-priority arbitration and trap handshake
module cpu_irq_ctrl #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 16,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mei_in,
  input  logic [2:0]         reg_addr,
  input  logic [XLEN-1:0]    reg_wdata,
  input  logic               reg_we,
  output logic [XLEN-1:0]    reg_rdata,
  input  logic               mstatus_mie,
  input  logic [XLEN-1:0]    mie,
  input  logic [XLEN-1:0]    mtvec,
  output logic               int_req,
  output logic [XLEN-1:0]    int_cause,
  output logic [XLEN-1:0]    int_target,
  input  logic               int_ack
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_nx;
  logic [63:0] mtime, mtimecmp;
  logic msip, mei_q, mti_q;
  logic [NUM_IRQ-1:0] lie, lip, irq_prev, lip_nx, lip_clr;
  logic [15:0] loc_e, ack_pad;
  logic mei_e, msi_e, mti_e, any_e, cur_e, ack_take;
  logic [4:0] loc_win, win, code;
  logic [XLEN-1:0] base, win_target;
  assign mei_e = mstatus_mie & mei_q & mie[11];
  assign msi_e = mstatus_mie & msip & mie[3];
  assign mti_e = mstatus_mie & mti_q & mie[7];
  assign loc_e = 16'(lip & lie & {NUM_IRQ{mstatus_mie}});
  assign any_e = mei_e | msi_e | mti_e | (|loc_e);
  always_comb begin
    loc_win = '0;
    for (int i = 15; i >= 0; i--) if (loc_e[i]) loc_win = 5'(16 + i);
  end
  assign win = mei_e ? 5'd11 : msi_e ? 5'd3 : mti_e ? 5'd7 : loc_win;
  assign base = {mtvec[XLEN-1:2], 2'b00};
  assign win_target = (mtvec[1:0] == 2'b01) ? base + XLEN'({win, 2'b00}) : base;
  // the latched request stays up only while its own source is still eligible
  assign code = int_cause[4:0];
  assign cur_e = (code == 5'd11) ? mei_e : (code == 5'd3) ? msi_e : (code == 5'd7) ? mti_e : code[4] & loc_e[code[3:0]];
  assign ack_take = (state == REQ) && int_ack;
  assign ack_pad = (ack_take && code[4]) ? 16'd1 << code[3:0] : '0;
  assign lip_clr = ((reg_we && reg_addr == 3'd6) ? reg_wdata[NUM_IRQ-1:0] : '0) | ack_pad[NUM_IRQ-1:0];
  assign lip_nx = (EDGE_MASK & ((irq_in & ~irq_prev) | (lip & ~lip_clr))) | (~EDGE_MASK & irq_in);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_e ? REQ : IDLE;
      REQ:     state_nx = int_ack ? HOLD : (cur_e ? REQ : IDLE);
      default: state_nx = IDLE;
    endcase
  end
  assign int_req = (state == REQ);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      lie        <= '0;
      lip        <= '0;
      irq_prev   <= '0;
      mei_q      <= 1'b0;
      mti_q      <= 1'b0;
      int_cause  <= '0;
      int_target <= '0;
    end else begin
      state    <= state_nx;
      mtime    <= (reg_we && reg_addr == 3'd0) ? {mtime[63:32], reg_wdata} :
                  (reg_we && reg_addr == 3'd1) ? {reg_wdata, mtime[31:0]} : mtime + 64'd1;
      mtimecmp <= (reg_we && reg_addr == 3'd2) ? {mtimecmp[63:32], reg_wdata} :
                  (reg_we && reg_addr == 3'd3) ? {reg_wdata, mtimecmp[31:0]} : mtimecmp;
      msip     <= (reg_we && reg_addr == 3'd4) ? reg_wdata[0] : msip;
      lie      <= (reg_we && reg_addr == 3'd5) ? reg_wdata[NUM_IRQ-1:0] : lie;
      lip      <= lip_nx;
      irq_prev <= irq_in;
      mei_q    <= mei_in;
      mti_q    <= mtime >= mtimecmp;
      if (state == IDLE && any_e) begin
        int_cause  <= {1'b1, {(XLEN-6){1'b0}}, win};
        int_target <= win_target;
      end
    end
  end
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = mtime[31:0];
      3'd1:    reg_rdata = mtime[63:32];
      3'd2:    reg_rdata = mtimecmp[31:0];
      3'd3:    reg_rdata = mtimecmp[63:32];
      3'd4:    reg_rdata = XLEN'(msip);
      3'd5:    reg_rdata = XLEN'(lie);
      3'd6:    reg_rdata = XLEN'(lip);
      default: reg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// tb_cpu_irq_ctrl: directed scoreboard bench; expected requests are queued by stimulus and checked by a monitor on each int_req rise
module tb_cpu_irq_ctrl;
  localparam int XLEN = 32;
  localparam int NUM_IRQ = 16;
  localparam logic [15:0] EM = 16'h0005;
  logic clk, rst, mei_in, reg_we, mstatus_mie, int_req, int_ack;
  logic [NUM_IRQ-1:0] irq_in;
  logic [2:0] reg_addr;
  logic [XLEN-1:0] reg_wdata, reg_rdata, mie, mtvec, int_cause, int_target;
  typedef struct packed {logic [31:0] cause; logic [31:0] target;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic req_d = 1'b0;

  cpu_irq_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .EDGE_MASK(EM)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mei_in(mei_in),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
    .mstatus_mie(mstatus_mie), .mie(mie), .mtvec(mtvec),
    .int_req(int_req), .int_cause(int_cause), .int_target(int_target), .int_ack(int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    chk(name, reg_rdata, exp);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!int_req && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_req"}, 32'(int_req), 32'd1);
  endtask

  task automatic ack(input string name, input logic [15:0] drop, input logic drop_mei);
    wait_req(name);
    int_ack = 1'b1;
    irq_in = irq_in & ~drop;
    if (drop_mei) mei_in = 1'b0;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] t);
    exp_t e;
    e.cause = c;
    e.target = t;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (int_req && !req_d) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got cause %h target %h expected no request", int_cause, int_target);
        end else begin
          e = exp_q.pop_front();
          chk("req_cause", int_cause, e.cause);
          chk("req_target", int_target, e.target);
        end
      end
      req_d = int_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq_in = '0; mei_in = 1'b0; reg_addr = '0; reg_wdata = '0; reg_we = 1'b0;
    mstatus_mie = 1'b0; mie = '0; mtvec = 32'h100; int_ack = 1'b0;
    tick(3);
    chk("rst_req", 32'(int_req), 0);
    chk("rst_cause", int_cause, 0);
    chk("rst_target", int_target, 0);
    rd("rst_mtime_lo", 0, 0);
    rd("rst_cmp_lo", 2, 32'hFFFF_FFFF);
    rd("rst_cmp_hi", 3, 32'hFFFF_FFFF);
    rd("rst_msip", 4, 0);
    rd("rst_lie", 5, 0);
    rd("rst_lip", 6, 0);
    rd("reg7", 7, 0);
    rst = 1'b0;
    tick(2);
    // MEI beats MSI raised in the same cycle; MSI follows after the ack
    mstatus_mie = 1'b1; mie = 32'h888;
    push(32'h8000_000B, 32'h100);
    push(32'h8000_0003, 32'h100);
    reg_addr = 4; reg_wdata = 32'hFFFF_FFFF; reg_we = 1'b1; mei_in = 1'b1;
    tick();
    reg_we = 1'b0;
    ack("mei", 16'h0, 1'b1);
    chk("hold_req", 32'(int_req), 0);
    tick();
    chk("idle_req", 32'(int_req), 0);
    tick();
    chk("spacing_req", 32'(int_req), 1);
    rd("msip_bit0", 4, 1);
    ack("msi", 16'h0, 1'b0);
    wr(4, 0);
    tick(4);
    chk("msi_done", 32'(int_req), 0);
    mie = '0;
    // vectored then direct target for edge source 2
    mtvec = 32'h101;
    wr(5, 32'h4);
    push(32'h8000_0012, 32'h148);
    irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0;
    ack("vec", 16'h0, 1'b0);
    rd("lip_ack_clr", 6, 0);
    tick(3);
    mtvec = 32'h100;
    push(32'h8000_0012, 32'h100);
    irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0;
    ack("direct", 16'h0, 1'b0);
    tick(3);
    // timer: mtime restarted at 0, cmp = 20
    wr(2, 20);
    wr(0, 0);
    wr(3, 0);
    mie = 32'h80;
    push(32'h8000_0007, 32'h100);
    reg_addr = 0;
    wait_req("mti");
    rd("mti_time", 0, 22);
    wr(3, 1);
    tick(2);
    chk("mti_withdraw", 32'(int_req), 0);
    mie = '0;
    wr(3, 32'hFFFF_FFFF);
    tick(2);
    // edge source 0: W1C, then set-wins race with a new edge
    mstatus_mie = 1'b0;
    wr(5, 32'h1);
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0; tick();
    rd("lip_edge", 6, 1);
    wr(6, 1);
    rd("lip_w1c", 6, 0);
    irq_in[0] = 1'b1; reg_addr = 6; reg_wdata = 1; reg_we = 1'b1;
    tick();
    reg_we = 1'b0; irq_in[0] = 1'b0;
    rd("lip_race", 6, 1);
    push(32'h8000_0010, 32'h100);
    mstatus_mie = 1'b1;
    ack("race", 16'h0, 1'b0);
    rd("lip_race_ack", 6, 0);
    tick(6);
    chk("no_second", 32'(int_req), 0);
    // level source 3: W1C ignored, withdraw on mstatus_mie, then reset in REQ
    wr(5, 32'h8);
    push(32'h8000_0013, 32'h100);
    irq_in[3] = 1'b1;
    wait_req("lvl");
    wr(6, 32'h8);
    rd("lip_level_w1c", 6, 32'h8);
    mstatus_mie = 1'b0;
    tick();
    chk("withdraw_req", 32'(int_req), 0);
    push(32'h8000_0013, 32'h100);
    mstatus_mie = 1'b1;
    wait_req("lvl2");
    rst = 1'b1;
    tick();
    chk("rst_req_in_req", 32'(int_req), 0);
    rd("rst2_mtime_lo", 0, 0);
    rd("rst2_mtime_hi", 1, 0);
    rd("rst2_cmp_lo", 2, 32'hFFFF_FFFF);
    rd("rst2_cmp_hi", 3, 32'hFFFF_FFFF);
    rd("rst2_lie", 5, 0);
    irq_in = '0;
    rst = 1'b0;
    tick(2);
    // lowest local index wins among level sources 3 and 5
    mtvec = 32'h101;
    wr(5, 32'h28);
    push(32'h8000_0013, 32'h14C);
    push(32'h8000_0015, 32'h154);
    irq_in = 16'h0028;
    ack("lo3", 16'h0008, 1'b0);
    ack("lo5", 16'h0020, 1'b0);
    tick(5);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
